// File: rtl/ppu_vram_responder.sv
// Memory-side responder for the PPU video-memory bus: low-address latch, CHR ROM/RAM and CIRAM with mirroring.
// Optional protocol monitor enabled by defining PPU_VRAM_BUS_MONITOR_EN.
module ppu_vram_responder #(
    parameter int CHR_AW   = 13,
    parameter bit CHR_RAM  = 1'b1,
    parameter int READ_LAT = 1
) (
    input  logic        CLK,
    input  logic        n_RES,
    input  logic        ALE,
    input  logic [7:0]  AD_in,
    output logic [7:0]  AD_out,
    output logic        AD_oe,
    input  logic [5:0]  A,
    input  logic        n_RD,
    input  logic        n_WR,
    input  logic [1:0]  MIR,
    input  logic        ld_we,
    input  logic        ld_sel,
    input  logic [12:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        bus_err,
    output logic [1:0]  err_code,
    output logic [1:0]  dbg_state
);
    // Handshake: a read starts on a sampled n_RD fall with ALE low; AD is driven until n_RD rises or ALE rises.
    // A write captures AD while n_WR is low and commits on the sampled n_WR rise.
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACT} state_t;

    state_t      state, state_nx;
    logic        ale_q, nrd_q, nwr_q, nrd_p, nwr_p;
    logic [7:0]  ad_q, lat_lo, rdata, wdata;
    logic [5:0]  a_q;
    logic [2:0]  cnt;
    logic [13:0] pa;
    logic        ciram_a10, rd_start, commit, bus_we, rd_fall, wr_fall;
    logic [12:0] bus_addr;
    logic [7:0]  mem_rd;
    logic        mem_we, mem_sel;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic        pend_valid, pend_sel;
    logic [12:0] pend_addr;
    logic [7:0]  pend_data;

    logic [7:0] chr_mem   [0:(1 << CHR_AW) - 1];
    logic [7:0] ciram_mem [0:2047];

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            ale_q  <= 1'b0;
            ad_q   <= 8'h00;
            a_q    <= 6'h00;
            nrd_q  <= 1'b1;
            nwr_q  <= 1'b1;
            nrd_p  <= 1'b1;
            nwr_p  <= 1'b1;
            lat_lo <= 8'h00;
        end else begin
            ale_q <= ALE;
            ad_q  <= AD_in;
            a_q   <= A;
            nrd_q <= n_RD;
            nwr_q <= n_WR;
            nrd_p <= nrd_q;
            nwr_p <= nwr_q;
            if (ale_q) lat_lo <= ad_q;
        end
    end

    assign pa      = {a_q, lat_lo};
    assign rd_fall = nrd_p & ~nrd_q;
    assign wr_fall = nwr_p & ~nwr_q;

    always_comb begin
        ciram_a10 = 1'b0;
        case (MIR)
            2'd0: ciram_a10 = pa[11];
            2'd1: ciram_a10 = pa[10];
            2'd2: ciram_a10 = 1'b0;
            2'd3: ciram_a10 = 1'b1;
            default: ciram_a10 = 1'b0;
        endcase
    end

    // 0x3F00-0x3FFF falls into CIRAM like the real board; palette lives inside the PPU.
    assign bus_addr = pa[13] ? {2'b00, ciram_a10, pa[9:0]} : pa[12:0];
    assign mem_rd   = pa[13] ? ciram_mem[bus_addr[10:0]] : chr_mem[bus_addr[CHR_AW-1:0]];

    always_comb begin
        state_nx = state;
        rd_start = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_fall) begin
                    state_nx = WR_ACT;
                end else if (rd_fall && !ale_q) begin
                    state_nx = RD_WAIT;
                    rd_start = 1'b1;
                end
            end
            RD_WAIT: begin
                if (nrd_q)          state_nx = IDLE;
                else if (cnt == 3'd0) state_nx = RD_DRIVE;
            end
            RD_DRIVE: begin
                if (nrd_q || ale_q) state_nx = IDLE;
            end
            WR_ACT: begin
                if (nwr_q) begin
                    commit   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus_we = commit && (pa[13] || CHR_RAM);

    // Single write port: loader first, then a deferred bus commit, then a fresh bus commit.
    always_comb begin
        mem_we   = 1'b0;
        mem_sel  = 1'b0;
        mem_addr = 13'h0000;
        mem_data = 8'h00;
        if (ld_we) begin
            mem_we   = 1'b1;
            mem_sel  = ld_sel;
            mem_addr = ld_addr;
            mem_data = ld_data;
        end else if (pend_valid) begin
            mem_we   = 1'b1;
            mem_sel  = pend_sel;
            mem_addr = pend_addr;
            mem_data = pend_data;
        end else if (bus_we) begin
            mem_we   = 1'b1;
            mem_sel  = pa[13];
            mem_addr = bus_addr;
            mem_data = wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            if (mem_sel) ciram_mem[mem_addr[10:0]] <= mem_data;
            else         chr_mem[mem_addr[CHR_AW-1:0]] <= mem_data;
        end
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            rdata      <= 8'h00;
            wdata      <= 8'h00;
            AD_oe      <= 1'b0;
            AD_out     <= 8'h00;
            pend_valid <= 1'b0;
            pend_sel   <= 1'b0;
            pend_addr  <= 13'h0000;
            pend_data  <= 8'h00;
        end else begin
            state <= state_nx;
            AD_oe <= (state_nx == RD_DRIVE);
            if (rd_start) begin
                cnt   <= 3'(READ_LAT - 1);
                rdata <= mem_rd;
            end else if (state == RD_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (state == RD_WAIT && state_nx == RD_DRIVE) AD_out <= rdata;
            if (!nwr_q) wdata <= ad_q;
            if (ld_we && bus_we && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_sel   <= pa[13];
                pend_addr  <= bus_addr;
                pend_data  <= wdata;
            end else if (!ld_we && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

`ifdef PPU_VRAM_BUS_MONITOR_EN
    logic       err_q;
    logic [1:0] code_q;

    // Sticky: only the first offending condition is recorded until reset.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            err_q  <= 1'b0;
            code_q <= 2'd0;
        end else if (!err_q) begin
            if (!nrd_q && !nwr_q) begin
                err_q  <= 1'b1;
                code_q <= 2'd1;
            end else if (ale_q && (!nrd_q || !nwr_q)) begin
                err_q  <= 1'b1;
                code_q <= 2'd2;
            end else if (ld_we && pend_valid) begin
                err_q  <= 1'b1;
                code_q <= 2'd3;
            end
        end
    end

    assign bus_err  = err_q;
    assign err_code = code_q;
`else
    assign bus_err  = 1'b0;
    assign err_code = 2'd0;
`endif
endmodule

// File: tb/tb_ppu_vram_responder.sv
// Directed bench for ppu_vram_responder: one CHR RAM instance (READ_LAT=1) and one CHR ROM instance (READ_LAT=3).
// Monitor checks adapt to PPU_VRAM_BUS_MONITOR_EN.
module tb_ppu_vram_responder;
    logic        clk = 1'b0;
    logic        n_res;
    logic        ale;
    logic [7:0]  ad_in;
    logic [5:0]  a;
    logic        n_rd, n_wr;
    logic [1:0]  mir;
    logic        ld_we, ld_sel;
    logic [12:0] ld_addr;
    logic [7:0]  ld_data;

    logic [7:0]  m_ad_out, r_ad_out;
    logic        m_ad_oe, r_ad_oe, m_bus_err, r_bus_err;
    logic [1:0]  m_err_code, r_err_code, m_state, r_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

`ifdef PPU_VRAM_BUS_MONITOR_EN
    localparam logic [7:0] EXP_ERR  = 8'd1;
    localparam logic [7:0] EXP_CODE = 8'd1;
`else
    localparam logic [7:0] EXP_ERR  = 8'd0;
    localparam logic [7:0] EXP_CODE = 8'd0;
`endif
    localparam logic [7:0] ST_IDLE     = 8'd0;
    localparam logic [7:0] ST_RD_DRIVE = 8'd2;

    typedef struct {
        logic [13:0] addr;
        logic [1:0]  mir;
        logic [7:0]  exp_main;
        logic [7:0]  exp_rom;
    } rd_vec_t;
    rd_vec_t vecs[11];

    ppu_vram_responder #(.CHR_AW(13), .CHR_RAM(1'b1), .READ_LAT(1)) u_main (
        .CLK(clk), .n_RES(n_res), .ALE(ale), .AD_in(ad_in), .AD_out(m_ad_out), .AD_oe(m_ad_oe),
        .A(a), .n_RD(n_rd), .n_WR(n_wr), .MIR(mir), .ld_we(ld_we), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .bus_err(m_bus_err), .err_code(m_err_code),
        .dbg_state(m_state)
    );

    ppu_vram_responder #(.CHR_AW(13), .CHR_RAM(1'b0), .READ_LAT(3)) u_rom (
        .CLK(clk), .n_RES(n_res), .ALE(ale), .AD_in(ad_in), .AD_out(r_ad_out), .AD_oe(r_ad_oe),
        .A(a), .n_RD(n_rd), .n_WR(n_wr), .MIR(mir), .ld_we(ld_we), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .bus_err(r_bus_err), .err_code(r_err_code),
        .dbg_state(r_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic load(input logic sel, input logic [12:0] addr, input logic [7:0] data);
        ld_we = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = data;
        tick(1);
        ld_we = 1'b0;
    endtask

    task automatic addr_phase(input logic [13:0] addr);
        ale = 1'b1; ad_in = addr[7:0]; a = addr[13:8];
        tick(1);
        ale = 1'b0;
    endtask

    task automatic bus_write(input logic [13:0] addr, input logic [7:0] data,
                             input logic do_ld, input logic [12:0] l_addr, input logic [7:0] l_data);
        addr_phase(addr);
        ad_in = data; n_wr = 1'b0;
        tick(2);
        n_wr = 1'b1;
        tick(1);
        if (do_ld) begin
            ld_we = 1'b1; ld_sel = 1'b1; ld_addr = l_addr; ld_data = l_data;
        end
        tick(1);
        ld_we = 1'b0;
        tick(2);
    endtask

    task automatic bus_read(input logic [13:0] addr, input string name);
        logic [7:0] em, er;
        addr_phase(addr);
        n_rd = 1'b0;
        tick(6);
        em = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        er = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({name, " main oe"},   {7'd0, m_ad_oe}, 8'd1);
        check({name, " main data"}, m_ad_out, em);
        check({name, " rom oe"},    {7'd0, r_ad_oe}, 8'd1);
        check({name, " rom data"},  r_ad_out, er);
        n_rd = 1'b1;
        tick(2);
        check({name, " main release"}, {7'd0, m_ad_oe}, 8'd0);
        check({name, " rom release"},  {7'd0, r_ad_oe}, 8'd0);
    endtask

    initial begin
        vecs[0]  = '{14'h2805, 2'd1, 8'h77, 8'h77};
        vecs[1]  = '{14'h2405, 2'd1, 8'h3C, 8'h3C};
        vecs[2]  = '{14'h2405, 2'd0, 8'h77, 8'h77};
        vecs[3]  = '{14'h2C05, 2'd0, 8'h3C, 8'h3C};
        vecs[4]  = '{14'h0010, 2'd0, 8'hFF, 8'h11};
        vecs[5]  = '{14'h0123, 2'd0, 8'h5A, 8'h5A};
        vecs[6]  = '{14'h2000, 2'd1, 8'hA5, 8'hA5};
        vecs[7]  = '{14'h23FF, 2'd1, 8'hC3, 8'hC3};
        vecs[8]  = '{14'h3C05, 2'd2, 8'h77, 8'h77};
        vecs[9]  = '{14'h3C05, 2'd3, 8'h3C, 8'h3C};
        vecs[10] = '{14'h3FFF, 2'd2, 8'hC3, 8'hC3};

        n_res = 1'b0; ale = 1'b0; ad_in = 8'h00; a = 6'h00; n_rd = 1'b1; n_wr = 1'b1;
        mir = 2'd0; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = 13'h0; ld_data = 8'h00;
        tick(2);
        check("reset main oe",    {7'd0, m_ad_oe}, 8'd0);
        check("reset main out",   m_ad_out, 8'h00);
        check("reset main state", {6'd0, m_state}, ST_IDLE);
        check("reset main err",   {7'd0, m_bus_err}, 8'd0);
        check("reset main code",  {6'd0, m_err_code}, 8'd0);
        check("reset rom oe",     {7'd0, r_ad_oe}, 8'd0);
        n_res = 1'b1;
        tick(2);

        load(1'b0, 13'h0123, 8'h5A);
        load(1'b0, 13'h0010, 8'h11);
        load(1'b1, 13'h405, 8'h3C);
        load(1'b1, 13'h005, 8'h00);

        // Read latency: main drives on the 3rd edge after the fall, releases 2 edges after the rise
        addr_phase(14'h0123);
        n_rd = 1'b0;
        tick(2);
        check("lat main oe early", {7'd0, m_ad_oe}, 8'd0);
        tick(1);
        check("lat main oe", {7'd0, m_ad_oe}, 8'd1);
        check("lat main data", m_ad_out, 8'h5A);
        tick(1);
        n_rd = 1'b1;
        tick(1);
        check("lat main oe held", {7'd0, m_ad_oe}, 8'd1);
        check("lat rom oe", {7'd0, r_ad_oe}, 8'd1);
        check("lat rom data", r_ad_out, 8'h5A);
        tick(1);
        check("lat main oe off", {7'd0, m_ad_oe}, 8'd0);
        check("lat rom oe off", {7'd0, r_ad_oe}, 8'd0);
        tick(2);

        mir = 2'd1;
        bus_write(14'h2005, 8'h77, 1'b0, 13'h0, 8'h00);
        bus_write(14'h0010, 8'hFF, 1'b0, 13'h0, 8'h00);
        // Bus commit lands in the same cycle as a loader write to CIRAM 0x3FF
        bus_write(14'h2000, 8'hA5, 1'b1, 13'h3FF, 8'hC3);

        for (int i = 0; i < 11; i++) begin
            mir = vecs[i].mir;
            exp_q.push_back(vecs[i].exp_main);
            exp_q.push_back(vecs[i].exp_rom);
            bus_read(vecs[i].addr, $sformatf("rd %04h mir%0d", vecs[i].addr, vecs[i].mir));
        end

        // One-cycle n_RD pulse never reaches the drive phase
        mir = 2'd0;
        addr_phase(14'h0123);
        n_rd = 1'b0;
        tick(1);
        n_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pulse main oe t%0d", i), {7'd0, m_ad_oe}, 8'd0);
            check($sformatf("pulse rom oe t%0d", i),  {7'd0, r_ad_oe}, 8'd0);
            tick(1);
        end

        // Asynchronous reset during drive
        addr_phase(14'h0123);
        n_rd = 1'b0;
        tick(3);
        check("rst-mid main oe before", {7'd0, m_ad_oe}, 8'd1);
        check("rst-mid main state", {6'd0, m_state}, ST_RD_DRIVE);
        #2 n_res = 1'b0;
        #1;
        check("rst-mid main oe", {7'd0, m_ad_oe}, 8'd0);
        check("rst-mid main out", m_ad_out, 8'h00);
        check("rst-mid main state idle", {6'd0, m_state}, ST_IDLE);
        n_rd = 1'b1;
        tick(1);
        n_res = 1'b1;
        tick(2);

        // Protocol monitor: both strobes low, then an ALE violation that must not overwrite the code
        n_rd = 1'b0; n_wr = 1'b0;
        tick(2);
        check("mon both err main",  {7'd0, m_bus_err}, EXP_ERR);
        check("mon both code main", {6'd0, m_err_code}, EXP_CODE);
        check("mon both err rom",   {7'd0, r_bus_err}, EXP_ERR);
        n_rd = 1'b1; n_wr = 1'b1;
        tick(3);
        ale = 1'b1; n_rd = 1'b0;
        tick(2);
        check("mon ale err main",  {7'd0, m_bus_err}, EXP_ERR);
        check("mon ale code main", {6'd0, m_err_code}, EXP_CODE);
        check("mon ale code rom",  {6'd0, r_err_code}, EXP_CODE);
        ale = 1'b0; n_rd = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
